ram_sp_fifo_ctrl: RTL and testbench

FIFO controller that sits directly upstream of the single-port synchronous-read RAM and drives its address, data_in and write_en pins. It presents valid/ready streaming interfaces on both sides. It shares the one RAM port between pushes and pops. It absorbs the RAM's one-cycle read latency with a one-entry output register, turning the 16x8 RAM into a 16+1-deep FIFO.

---
 rtl/ram_sp_fifo_pkg.sv | 11 +
 rtl/ram_sp_fifo_ptr.sv | 48 ++++
 rtl/ram_sp_fifo_ctrl.sv | 103 ++++++++++
 tb/tb_ram_sp_fifo_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_sp_fifo_pkg.sv
// Shared defaults for the single-port-RAM FIFO controller.
// Optional level flags are enabled with the RAM_SP_FIFO_LEVEL_FLAGS_EN macro (see top).
package ram_sp_fifo_pkg;

  localparam int FIFO_DATA_W = 8;
  localparam int FIFO_ADDR_W = 4;
  localparam int FIFO_DEPTH  = 2 ** FIFO_ADDR_W;
  // count spans 0..DEPTH+1 (RAM + in-flight read + output register)
  localparam int FIFO_CNT_W  = FIFO_ADDR_W + 1;

endpackage

// File: rtl/ram_sp_fifo_ptr.sv
// Wrapping write/read pointer pair and RAM occupancy counter.
// inc_wr and inc_rd are never asserted together by the controller, but the
// counter holds its value if they ever are.
module ram_sp_fifo_ptr
  import ram_sp_fifo_pkg::*;
#(
  parameter int ADDR_W = FIFO_ADDR_W,
  parameter int DEPTH  = FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc_wr,
  input  logic              inc_rd,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] rd_ptr,
  output logic [ADDR_W:0]   ram_cnt,
  output logic              full
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  // Pointers wrap naturally because DEPTH == 2**ADDR_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (inc_wr) wr_ptr <= wr_ptr + 1'b1;
      if (inc_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // RAM occupancy: +1 per write, -1 per read issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_cnt <= '0;
    end else begin
      case ({inc_wr, inc_rd})
        2'b10:   ram_cnt <= ram_cnt + 1'b1;
        2'b01:   ram_cnt <= ram_cnt - 1'b1;
        default: ram_cnt <= ram_cnt;
      endcase
    end
  end

  assign full = (ram_cnt == FULL_CNT);

endmodule

// File: rtl/ram_sp_fifo_ctrl.sv
// FIFO controller driving one single-port, synchronous-read RAM.
// Pushes and pops share the RAM port; a read request always wins the port.
// A one-entry output register hides the RAM read latency (DEPTH+1 words total).
// Define RAM_SP_FIFO_LEVEL_FLAGS_EN to add AF_LEVEL/AE_LEVEL and the
// almost_full/almost_empty outputs.
//
// Handshakes: a word moves on a rising edge where valid && ready are both high.
// Producers must hold data stable while valid && !ready; in_ready may depend
// combinationally on out_ready, out_valid/out_data never depend on inputs.
module ram_sp_fifo_ctrl
  import ram_sp_fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int ADDR_W = FIFO_ADDR_W,
  parameter int DEPTH  = FIFO_DEPTH
`ifdef RAM_SP_FIFO_LEVEL_FLAGS_EN
  ,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_write_en,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full
`ifdef RAM_SP_FIFO_LEVEL_FLAGS_EN
  ,
  output logic              almost_full,
  output logic              almost_empty
`endif
);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   ram_cnt;
  logic              rd_req;
  logic              rd_pend;
  logic              push;

  // Issue a read when the RAM holds data, nothing is in flight, and the
  // output register will be free at the edge the data lands.
  assign rd_req   = (ram_cnt != '0) && !rd_pend && (!out_valid || out_ready);
  assign in_ready = !full && !rd_req;
  assign push     = in_valid && in_ready;

  // RAM port: read address takes priority; writes are blocked during reset.
  assign ram_address  = rd_req ? rd_ptr : wr_ptr;
  assign ram_write_en = push && rst_n;
  assign ram_data_in  = in_data;

  ram_sp_fifo_ptr #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ptr (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_wr  (push),
    .inc_rd  (rd_req),
    .wr_ptr  (wr_ptr),
    .rd_ptr  (rd_ptr),
    .ram_cnt (ram_cnt),
    .full    (full)
  );

  // Read-in-flight flag: set the edge a read issues, cleared at capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_pend <= 1'b0;
    else        rd_pend <= rd_req;
  end

  // Output register: capture RAM data one edge after issue, else drop on pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (rd_pend) begin
      out_valid <= 1'b1;
      out_data  <= ram_data_out;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign count = ram_cnt + {{ADDR_W{1'b0}}, rd_pend} + {{ADDR_W{1'b0}}, out_valid};
  assign empty = (count == '0);

`ifdef RAM_SP_FIFO_LEVEL_FLAGS_EN
  assign almost_full  = (count >= (ADDR_W + 1)'(AF_LEVEL));
  assign almost_empty = (count <= (ADDR_W + 1)'(AE_LEVEL));
`endif

endmodule

// File: tb/tb_ram_sp_fifo_ctrl.sv
// Bench for ram_sp_fifo_ctrl with a behavioural 16x8 single-port sync-read RAM.
module tb_ram_sp_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [3:0] ram_address;
  logic [7:0] ram_data_in;
  logic       ram_write_en;
  logic [7:0] ram_data_out;
  logic [4:0] count;
  logic       empty;
  logic       full;
`ifdef RAM_SP_FIFO_LEVEL_FLAGS_EN
  logic       almost_full;
  logic       almost_empty;
`endif

  logic [7:0] exp_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         wr_m = 0;
  int         rd_m = 0;
  logic [7:0] mem [16];

  // clock / reset
  always #5 clk = ~clk;

  ram_sp_fifo_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .ram_address  (ram_address),
    .ram_data_in  (ram_data_in),
    .ram_write_en (ram_write_en),
    .ram_data_out (ram_data_out),
    .count        (count),
    .empty        (empty),
    .full         (full)
`ifdef RAM_SP_FIFO_LEVEL_FLAGS_EN
    ,
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`endif
  );

  // single-port RAM, registered read (read-before-write)
  always @(posedge clk) begin
    if (ram_write_en) mem[ram_address] <= ram_data_in;
    ram_data_out <= mem[ram_address];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: offer one word, wait (bounded) for acceptance; in_valid stays high
  task automatic push_word(input logic [7:0] d);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        check("push_we", 32'(ram_write_en), 32'd1);
        check("push_addr", 32'(ram_address), 32'(wr_m));
        exp_q.push_back(d);
        wr_m = (wr_m + 1) % 16;
        done = 1'b1;
      end else if (!full) begin
        check("rd_addr", 32'(ram_address), 32'(rd_m));
        check("rd_we", 32'(ram_write_en), 32'd0);
        rd_m = (rd_m + 1) % 16;
      end
      @(posedge clk);
      #1;
    end
    if (!done) check("push_timeout", 32'd0, 32'd1);
  endtask

  // driver: take exactly one word once out_valid is present
  task automatic pop_one();
    for (int i = 0; i < 20 && !out_valid; i++) begin
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  // wait until the scoreboard is drained, then check the FIFO is empty
  task automatic wait_drain(input string name);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check({name, "_q"}, 32'(exp_q.size()), 32'd0);
    check({name, "_count"}, 32'(count), 32'd0);
    check({name, "_empty"}, 32'(empty), 32'd1);
    rd_m = wr_m;
  endtask

  // scoreboard monitor: compare each word the consumer takes
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL out_unexpected: got 0x%0h expected no word", out_data);
        end else begin
          e = exp_q.pop_front();
          check("out_data", 32'(out_data), 32'(e));
        end
      end
    end
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int cyc;
    int last;
    int pops;

    // reset with a push request present
    in_valid = 1'b1;
    #3;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_we", 32'(ram_write_en), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    in_valid = 1'b0;
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single push, latency 3 edges
    out_ready = 1'b1;
    push_word(8'hA5);
    in_valid = 1'b0;
    check("single_count", 32'(count), 32'd1);
    lat = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'd3);
    @(posedge clk);
    #1;
    check("single_count0", 32'(count), 32'd0);
    check("single_empty", 32'(empty), 32'd1);
    rd_m = wr_m;

    // fill: 17 words with consumer stalled
    out_ready = 1'b0;
    for (int i = 1; i <= 17; i++) push_word(8'(i));
    in_data = 8'h12;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_in_ready", 32'(in_ready), 32'd0);
      check("full_we", 32'(ram_write_en), 32'd0);
      check("full_flag", 32'(full), 32'd1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("fill_count", 32'(count), 32'd17);
    check("fill_out_valid", 32'(out_valid), 32'd1);
    check("fill_out_data", 32'(out_data), 32'h01);

    // drain: one pop every second cycle
    out_ready = 1'b1;
    cyc = 0;
    last = 0;
    pops = 0;
    for (int i = 0; i < 100 && pops < 17; i++) begin
      @(negedge clk);
      if (out_valid) begin
        if (pops > 0) check("pop_gap", 32'(cyc - last), 32'd2);
        last = cyc;
        pops++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    check("drain_pops", 32'(pops), 32'd17);
    wait_drain("drain");

    // continuous in_valid while the output register drains
    for (int i = 0; i < 8; i++) push_word(8'h40 + 8'(i));
    in_valid = 1'b0;
    wait_drain("stream");

    // reset while a read is in flight, holding 5 words
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_word(8'h50 + 8'(i));
    in_valid = 1'b0;
    check("pre_rst_count", 32'(count), 32'd5);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("mid_count", 32'(count), 32'd4);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_empty", 32'(empty), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    wr_m = 0;
    rd_m = 0;
    push_word(8'h3C);
    in_valid = 1'b0;
    wait_drain("post_rst");

`ifdef RAM_SP_FIFO_LEVEL_FLAGS_EN
    // level flags
    out_ready = 1'b0;
    for (int i = 0; i < 13; i++) push_word(8'h60 + 8'(i));
    check("af13_count", 32'(count), 32'd13);
    check("af13", 32'(almost_full), 32'd0);
    push_word(8'h6D);
    in_valid = 1'b0;
    check("af14_count", 32'(count), 32'd14);
    check("af14", 32'(almost_full), 32'd1);
    check("ae14", 32'(almost_empty), 32'd0);
    for (int i = 0; i < 11; i++) pop_one();
    check("ae3_count", 32'(count), 32'd3);
    check("ae3", 32'(almost_empty), 32'd0);
    pop_one();
    check("ae2_count", 32'(count), 32'd2);
    check("ae2", 32'(almost_empty), 32'd1);
    check("af2", 32'(almost_full), 32'd0);
    out_ready = 1'b1;
    wait_drain("flags");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
